// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter.
//   REG_COUNT / REG_ADDR_W : architectural register count and address width
//   ZERO_REG               : hard-wired zero register; writes to it are dropped
//   WB_N / wb_req_t        : default-width write request {rd, data}
//   rd_live()              : true when a destination register is a real write
package regfile_wb_arbiter_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  localparam int WB_N = 32;

  // Field order matters: the FIFO and the hazard compare take rd from the
  // top REG_ADDR_W bits of a packed request.
  typedef struct packed {
    reg_addr_t       rd;
    logic [WB_N-1:0] data;
  } wb_req_t;

  function automatic logic rd_live(input reg_addr_t rd);
    return rd != ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two write-back producers, the hazard logic and the
// register file write port.
//   a_*       : in-order pipeline write-back (no back-pressure), a_stall back
//   b_*       : multi-cycle unit request with valid/ready
//   q_rs*     : hazard query addresses, pend_hit* answers
//   rf_*      : registered register-file write port
// Modports: master = producers/consumers around the arbiter, slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int N = 32
);
  import regfile_wb_arbiter_pkg::*;

  logic          a_valid;
  reg_addr_t     a_rd;
  logic [N-1:0]  a_data;
  logic          a_stall;

  // Valid/ready: a B transfer happens on a rising edge where b_valid and
  // b_ready are both 1. b_ready is registered and does not depend on b_valid.
  logic          b_valid;
  logic          b_ready;
  reg_addr_t     b_rd;
  logic [N-1:0]  b_data;

  reg_addr_t     q_rs1;
  reg_addr_t     q_rs2;
  logic          pend_hit1;
  logic          pend_hit2;

  logic          rf_we;
  reg_addr_t     rf_waddr;
  logic [N-1:0]  rf_wdata;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data, q_rs1, q_rs2,
    input  a_stall, b_ready, pend_hit1, pend_hit2, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, q_rs1, q_rs2,
    output a_stall, b_ready, pend_hit1, pend_hit2, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Synchronous FIFO buffering multi-cycle write-back requests.
//   clk, rst    : clock, synchronous active-low reset
//   push, din   : enqueue din (caller guarantees !full)
//   pop, dout   : dequeue head; dout always shows the head
//   full, empty : occupancy flags
//   count       : number of held entries
//   ent_rd      : destination register field of every slot
//   ent_valid   : slot holds a live entry
// Each element is a packed request with rd in its top REG_ADDR_W bits.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int W     = REG_ADDR_W + 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [W-1:0]                     din,
  input  logic                             pop,
  output logic [W-1:0]                     dout,
  output logic                             full,
  output logic                             empty,
  output logic [CNT_W-1:0]                 count,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd,
  output logic [DEPTH-1:0]                 ent_valid
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [DEPTH-1:0] valid;

  // Payload storage carries no reset; only the control state does.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      valid  <= '0;
    end else begin
      // Pop before push so a slot reused in the same cycle ends up valid.
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    ent_rd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd[i] = mem[i][W-1 -: REG_ADDR_W];
    end
  end

  assign dout      = mem[rd_ptr];
  assign count     = cnt;
  assign full      = (cnt == CNT_W'(DEPTH));
  assign empty     = (cnt == '0);
  assign ent_valid = valid;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the in-order pipeline
// (port A, highest priority, no back-pressure) and a multi-cycle unit
// (port B, valid/ready, buffered in wb_fifo).
//   clk, rst : clock, synchronous active-low reset
//   bus      : regfile_wb_arbiter_if slave modport (A/B requests, hazard
//              query, registered register-file write port, a_stall)
// Parameters: N data width, DEPTH FIFO entries (power of two, >= 2),
// STARVE_MAX denied cycles of a non-empty FIFO before a_stall fires.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N          = WB_N,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    reg_addr_t    rd;
    logic [N-1:0] data;
  } req_t;

  logic                             a_live;
  logic                             b_accept;
  logic                             push;
  logic                             pop;
  req_t                             push_req;
  req_t                             head;
  logic                             full;
  logic                             empty;
  logic [CNT_W-1:0]                 count;
  logic [CNT_W-1:0]                 cnt_nxt;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
  logic [DEPTH-1:0]                 ent_valid;

  logic                             b_ready_q;
  logic                             a_stall_q;
  logic [SC_W-1:0]                  starve_cnt;
  logic                             rf_we_q;
  reg_addr_t                        rf_waddr_q;
  logic [N-1:0]                     rf_wdata_q;
  logic                             hit1;
  logic                             hit2;

  // A write to the zero register is no write at all, so the FIFO may use
  // that cycle; likewise a B request to rd 0 is consumed but never stored.
  assign a_live   = bus.a_valid && rd_live(bus.a_rd);
  assign b_accept = bus.b_valid && b_ready_q;
  assign push     = b_accept && rd_live(bus.b_rd);
  assign pop      = !a_live && !empty;
  assign push_req = '{rd: bus.b_rd, data: bus.b_data};

  wb_fifo #(
    .W     ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (push_req),
    .pop       (pop),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ent_rd    (ent_rd),
    .ent_valid (ent_valid)
  );

  // b_ready is registered from the post-edge occupancy, so it never offers a
  // slot the FIFO will not have.
  always_comb begin
    cnt_nxt = count;
    if (push && !pop) begin
      cnt_nxt = count + 1'b1;
    end else if (pop && !push) begin
      cnt_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      b_ready_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      b_ready_q <= (cnt_nxt < CNT_W'(DEPTH));
      if (a_live) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= bus.a_rd;
        rf_wdata_q <= bus.a_data;
      end else if (pop) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= head.rd;
        rf_wdata_q <= head.data;
      end else begin
        rf_we_q    <= 1'b0;
      end
    end
  end

  // A non-empty FIFO that is not popped means A took the port this cycle.
  // Reaching STARVE_MAX such cycles raises a_stall for exactly one cycle,
  // during which upstream idles and the head drains.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      a_stall_q  <= 1'b0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
      a_stall_q  <= 1'b0;
    end else if (starve_cnt == SC_W'(STARVE_MAX - 1)) begin
      starve_cnt <= '0;
      a_stall_q  <= 1'b1;
    end else begin
      starve_cnt <= starve_cnt + 1'b1;
      a_stall_q  <= 1'b0;
    end
  end

  // A register is pending while it sits in the FIFO or is on the write port
  // this cycle (the register file only holds it from the next edge).
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_rd[i] == bus.q_rs1) hit1 = 1'b1;
      if (ent_valid[i] && ent_rd[i] == bus.q_rs2) hit2 = 1'b1;
    end
    if (rf_we_q && rf_waddr_q == bus.q_rs1) hit1 = 1'b1;
    if (rf_we_q && rf_waddr_q == bus.q_rs2) hit2 = 1'b1;
    if (!rd_live(bus.q_rs1)) hit1 = 1'b0;
    if (!rd_live(bus.q_rs2)) hit2 = 1'b0;
  end

  assign bus.b_ready   = b_ready_q;
  assign bus.a_stall   = a_stall_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.pend_hit1 = hit1;
  assign bus.pend_hit2 = hit2;

  // Upstream must idle while a_stall is high; A still wins if it does not.
  assert property (@(posedge clk) disable iff (!rst) !(a_stall_q && bus.a_valid));

  assert property (@(posedge clk) disable iff (!rst) push |-> !full);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  logic [36:0] exp_q[$];

  regfile_wb_arbiter_if #(.N(32)) bus ();

  regfile_wb_arbiter #(
    .N          (32),
    .DEPTH      (2),
    .STARVE_MAX (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.a_rd    = '0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_rd    = '0;
    bus.b_data  = '0;
    bus.q_rs1   = '0;
    bus.q_rs2   = '0;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.a_valid = v;
    bus.a_rd    = rd;
    bus.a_data  = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.b_valid = v;
    bus.b_rd    = rd;
    bus.b_data  = d;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold a FIFO entry while A writes every cycle; the stall must come after
  // exactly 8 denials and the held entry must drain in the stall cycle.
  task automatic starve_run(input logic [4:0] rd, input logic [31:0] d);
    drive_b(1'b1, rd, d);
    drive_a(1'b1, 5'd10, 32'hA0);
    tick();
    drive_b(1'b0, '0, '0);
    check("starve_push_no_stall", bus.a_stall, 0);
    for (int k = 1; k <= 7; k++) begin
      bus.a_data = 32'hA0 + k;
      tick();
      check("starve_wait_no_stall", bus.a_stall, 0);
    end
    bus.a_data = 32'hB0;
    tick();
    check("starve_stall_high", bus.a_stall, 1);
    check("starve_a_still_written", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd10, 32'hB0});
    drive_a(1'b0, '0, '0);
    tick();
    check("starve_drain_write", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, rd, d});
    check("starve_stall_one_cycle", bus.a_stall, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [36:0] exp_w;
    n_vec = 0;
    n_err = 0;
    idle_inputs();

    // Reset hold with an A request present.
    rst = 1'b0;
    drive_a(1'b1, 5'd5, 32'h5555);
    repeat (3) tick();
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_waddr", bus.rf_waddr, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_b_ready", bus.b_ready, 0);
    check("rst_a_stall", bus.a_stall, 0);
    rst = 1'b1;
    drive_a(1'b0, '0, '0);
    tick();
    check("post_rst_b_ready", bus.b_ready, 1);
    check("post_rst_rf_we", bus.rf_we, 0);

    // A only.
    drive_a(1'b1, 5'd3, 32'hDEADBEEF);
    tick();
    check("a_only_write", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd3, 32'hDEADBEEF});
    drive_a(1'b1, 5'd0, 32'h12345678);
    tick();
    check("a_rd0_no_we", bus.rf_we, 0);
    check("a_rd0_hold", {bus.rf_waddr, bus.rf_wdata}, {5'd3, 32'hDEADBEEF});

    // Contention: B fills the FIFO while A writes rd 1,2,3.
    drive_a(1'b1, 5'd1, 32'h100);
    drive_b(1'b1, 5'd7, 32'h11);
    tick();
    check("cont_a1", bus.rf_waddr, 1);
    check("cont_ready_one_held", bus.b_ready, 1);
    drive_a(1'b1, 5'd2, 32'h200);
    drive_b(1'b1, 5'd8, 32'h22);
    tick();
    check("cont_a2", bus.rf_waddr, 2);
    check("cont_ready_full", bus.b_ready, 0);
    drive_a(1'b1, 5'd3, 32'h300);
    drive_b(1'b0, '0, '0);
    tick();
    check("cont_a3", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd3, 32'h300});
    check("cont_ready_still_full", bus.b_ready, 0);
    drive_a(1'b0, '0, '0);
    exp_q.push_back({5'd7, 32'h11});
    exp_q.push_back({5'd8, 32'h22});
    for (int k = 0; k < 2; k++) begin
      tick();
      exp_w = exp_q.pop_front();
      check("cont_drain_we", bus.rf_we, 1);
      check("cont_drain_order", {bus.rf_waddr, bus.rf_wdata}, exp_w);
      check("cont_ready_back", bus.b_ready, 1);
    end
    tick();
    check("cont_idle_no_we", bus.rf_we, 0);

    // Hazard query.
    drive_a(1'b1, 5'd1, 32'h1111);
    drive_b(1'b1, 5'd9, 32'h99);
    tick();
    drive_b(1'b0, '0, '0);
    bus.q_rs1 = 5'd9;
    bus.q_rs2 = 5'd0;
    #1;
    check("haz_fifo_hit1", bus.pend_hit1, 1);
    check("haz_zero_hit2", bus.pend_hit2, 0);
    bus.q_rs2 = 5'd1;
    #1;
    check("haz_wport_hit2", bus.pend_hit2, 1);
    bus.q_rs2 = 5'd0;
    drive_a(1'b0, '0, '0);
    tick();
    check("haz_pop_write", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 5'd9, 32'h99});
    check("haz_hit_on_wport", bus.pend_hit1, 1);
    tick();
    check("haz_we_dropped", bus.rf_we, 0);
    check("haz_hit_cleared", bus.pend_hit1, 0);
    bus.q_rs1 = 5'd0;

    // Starvation, twice to show the counter restarts from zero.
    starve_run(5'd4, 32'h44);
    starve_run(5'd5, 32'h55);

    // B request to rd 0 is swallowed.
    drive_b(1'b1, 5'd0, 32'hBAD);
    tick();
    drive_b(1'b0, '0, '0);
    check("b_rd0_no_we", bus.rf_we, 0);
    check("b_rd0_ready", bus.b_ready, 1);
    tick();
    check("b_rd0_nothing_queued", bus.rf_we, 0);

    // Reset with two entries queued.
    drive_a(1'b1, 5'd11, 32'hB1);
    drive_b(1'b1, 5'd12, 32'hC1);
    tick();
    drive_b(1'b1, 5'd13, 32'hC2);
    tick();
    check("mid_full_ready", bus.b_ready, 0);
    drive_b(1'b0, '0, '0);
    drive_a(1'b0, '0, '0);
    bus.q_rs1 = 5'd12;
    #1;
    check("mid_pending_before_rst", bus.pend_hit1, 1);
    rst = 1'b0;
    tick();
    check("mid_rst_write_port", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b0, 5'd0, 32'h0});
    check("mid_rst_b_ready", bus.b_ready, 0);
    check("mid_rst_a_stall", bus.a_stall, 0);
    check("mid_rst_no_pending", bus.pend_hit1, 0);
    rst = 1'b1;
    tick();
    check("mid_release_ready", bus.b_ready, 1);
    check("mid_release_no_we", bus.rf_we, 0);
    tick();
    check("mid_release_still_no_we", bus.rf_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two producers.
  - Port A is the in-order pipeline write-back. It has highest priority and no back-pressure.
  - Port B is a multi-cycle unit (mul/div/load-miss) using a valid/ready handshake, buffered in a small FIFO.
- Drives registered we/waddr/wdata into the register file.
- Reports which registers have a pending buffered write, so hazard logic can stall readers.
- Starvation guard: forces a one-cycle pipeline stall so port B drains.

Parameters:
- N, 32, data width; equals register file data width.
- DEPTH, 2, port-B FIFO entries; power of two, at least 2.
- STARVE_MAX, 8, consecutive denied cycles of a non-empty FIFO before a_stall is raised.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, reset; synchronous, active-low.
- a_valid, input, 1, pipeline write-back request.
- a_rd, input, 5, pipeline destination register.
- a_data, input, N, pipeline write data.
- a_stall, output, 1, registered; upstream must hold a_valid=0 in the cycle this is high.
- b_valid, input, 1, multi-cycle unit request.
- b_ready, output, 1, registered; FIFO can accept.
- b_rd, input, 5, multi-cycle destination register.
- b_data, input, N, multi-cycle write data.
- q_rs1, input, 5, hazard query address 1.
- q_rs2, input, 5, hazard query address 2.
- pend_hit1, output, 1, combinational; q_rs1 has a pending write.
- pend_hit2, output, 1, combinational; q_rs2 has a pending write.
- rf_we, output, 1, registered; register file write enable.
- rf_waddr, output, 5, registered; register file write address.
- rf_wdata, output, N, registered; register file write data.

Behaviour:
- Reset (rst=0 at a rising edge) clears the following; it wins over every other event in that cycle, including mid-drain and mid-stall:
  - FIFO emptied, pointers and count set to 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - a_stall=0, starvation counter=0, b_ready=0.
- b_ready=1 from the first post-reset edge whenever the FIFO count < DEPTH.
- B accept (b_valid & b_ready):
  - b_rd!=0: enqueue {b_rd, b_data}.
  - b_rd==0: accept and discard; nothing is enqueued.
- A request is live when a_valid=1 and a_rd!=0. a_rd==0 is treated as idle, so the FIFO may drain that cycle.
- Grant, evaluated each cycle:
  - A live: the next-edge output write is A.
  - Else FIFO non-empty: pop the head and write it.
  - Else rf_we=0 next cycle; rf_waddr and rf_wdata hold their values.
- Latency: exactly 1 cycle from a granted request to rf_we/rf_waddr/rf_wdata.
- Enqueue and pop may occur in the same cycle; the count is unchanged.
- There is no pass-through. A B item accepted into an empty FIFO is writable no earlier than 1 cycle later, giving 2 cycles minimum B-to-rf_we.
- Write order:
  - FIFO entries are written in acceptance order.
  - Two B writes to the same rd land in order.
  - A write and a buffered B write to the same rd land in grant order; the producers must not overlap the same rd.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and A is granted.
  - Counter clears on any FIFO pop, or when the FIFO is empty.
  - When the counter reaches STARVE_MAX, a_stall=1 for the next cycle only, and the counter clears.
  - In that cycle the FIFO head is granted.
- Protocol violation: if a_valid=1 while a_stall=1, A still wins (A is never dropped) and the FIFO waits. A simulation-only assertion flags this.
- pend_hitK=1 when q_rsK!=0 and either of these holds:
  - it matches the rd of any valid FIFO entry;
  - it matches rf_waddr while rf_we=1.
- q_rsK==0 never hits.

Decomposition:
- Shared package:
  - REG_ADDR_W=5, REG_COUNT=32, ZERO_REG=0.
  - A typedef for the write request {rd[4:0], data[N-1:0]}.
- One sub-module: wb_fifo.
  - Synchronous DEPTH-entry FIFO with push/pop/full/empty/count.
  - Per-entry rd and valid vectors exported for the hazard compare.
- The top level holds the grant logic, starvation counter, output register and hazard compare.

Test Plan:
- Reset hold: rst=0 for 3 cycles with a_valid=1, a_rd=5 → rf_we=0, b_ready=0, a_stall=0. First cycle after release: b_ready=1.
- A only: a_valid=1, a_rd=3, a_data=0xDEADBEEF in cycle t → rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF in t+1. a_rd=0 → rf_we=0.
- Contention, DEPTH=2: the following stimulus must produce the listed response.
  - Stimulus:
    - B pushes rd=7/0x11 and rd=8/0x22 while A writes rd=1,2,3 back-to-back.
  - Response:
    - b_ready=0 once 2 entries are held.
    - After A idles: rd=7/0x11 then rd=8/0x22 on consecutive cycles.
    - b_ready returns to 1.
- Hazard: FIFO holds rd=9, q_rs1=9, q_rs2=0 → pend_hit1=1, pend_hit2=0. After the pop and write, pend_hit1=0 one cycle after rf_we for rd 9 drops.
- Starvation, STARVE_MAX=8: FIFO holds rd=4, A writes continuously → a_stall=1 for exactly 1 cycle after 8 denials. With a_valid=0 in that cycle, the next cycle shows rf_waddr=4, and the counter restarts.
- B rd=0 and reset mid-drain:
  - B push with rd=0 → accepted, FIFO count unchanged, no rf_we.
  - rst=0 with 2 entries queued → FIFO empty and no further rf_we after release.
